control_sequencer: RTL

//  Parametrised hardwired control sequencer for the DataPath; replaces hand-stepped T0..T5 control.

---
 rtl/ctrl_pkg.sv | 46 ++++
 rtl/onehot_decoder.sv | 20 ++
 rtl/control_sequencer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, state codes and IR field layout.
package ctrl_pkg;

  // Register fields sit directly below the opcode, RA first, each REG_FIELD_W bits wide.
  localparam int REG_FIELD_W = 4;
  localparam int RA_POS = 1;
  localparam int RB_POS = 2;
  localparam int RC_POS = 3;

  localparam logic [31:0] OPC_ADD = 32'd3;
  localparam logic [31:0] OPC_SUB = 32'd4;
  localparam logic [31:0] OPC_AND = 32'd5;
  localparam logic [31:0] OPC_OR  = 32'd6;
  localparam logic [31:0] OPC_SHR = 32'd7;
  localparam logic [31:0] OPC_SHL = 32'd9;
  localparam logic [31:0] OPC_ROR = 32'd10;
  localparam logic [31:0] OPC_ROL = 32'd11;
  localparam logic [31:0] OPC_MUL = 32'd15;
  localparam logic [31:0] OPC_DIV = 32'd16;

  localparam logic [3:0] S_RESET = 4'd0;
  localparam logic [3:0] S_HALT  = 4'd1;
  localparam logic [3:0] S_T0    = 4'd2;
  localparam logic [3:0] S_T1    = 4'd3;
  localparam logic [3:0] S_T2    = 4'd4;
  localparam logic [3:0] S_T3    = 4'd5;
  localparam logic [3:0] S_T4    = 4'd6;
  localparam logic [3:0] S_T5    = 4'd7;
  localparam logic [3:0] S_T6    = 4'd8;
  localparam logic [3:0] S_WAIT  = 4'd9;

  function automatic logic is_multicycle(input logic [31:0] opc);
    return (opc == OPC_MUL) || (opc == OPC_DIV);
  endfunction

  function automatic logic is_legal_op(input logic [31:0] opc);
    logic legal;
    case (opc)
      OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_SHR,
      OPC_SHL, OPC_ROR, OPC_ROL, OPC_MUL, OPC_DIV: legal = 1'b1;
      default:                                     legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Register index to one-hot select; an index beyond NUM_REGS or a low enable yields all zeros.
module onehot_decoder
  import ctrl_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = REG_FIELD_W
)(
  input  logic                en,
  input  logic [IDX_W-1:0]    idx,
  output logic [NUM_REGS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      onehot[i] = en && (int'(idx) == i);
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer for R-format ALU ops with memory stall,
// multi-cycle MUL/DIV handshake, run/halt control and a sticky fault trap.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int OPC_W    = 5,
  parameter int ALU_TMO  = 64
)(
  input  logic                Clock,
  input  logic                clear,
  input  logic                run,
  input  logic [DATA_W-1:0]   ir,
  input  logic                mem_rdy,
  input  logic                alu_done,
  output logic                PCout,
  output logic                Zlowout,
  output logic                Zhighout,
  output logic                MDRout,
  output logic                MARin,
  output logic                PCin,
  output logic                MDRin,
  output logic                IRin,
  output logic                Yin,
  output logic                Zin,
  output logic                HIin,
  output logic                LOin,
  output logic                IncPC,
  output logic                Read,
  output logic [NUM_REGS-1:0] reg_out,
  output logic [NUM_REGS-1:0] reg_in,
  output logic [OPC_W-1:0]    alu_op,
  output logic                alu_start,
  output logic                halted,
  output logic                fault
);

  localparam int TMO_W  = $clog2(ALU_TMO + 1);
  localparam int RA_LSB = DATA_W - OPC_W - RA_POS * REG_FIELD_W;
  localparam int RB_LSB = DATA_W - OPC_W - RB_POS * REG_FIELD_W;
  localparam int RC_LSB = DATA_W - OPC_W - RC_POS * REG_FIELD_W;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ALU_TMO - 1);

  logic [OPC_W-1:0]       ir_opc;
  logic [REG_FIELD_W-1:0] ir_ra, ir_rb, ir_rc;
  logic                   unused_ir;

  assign ir_opc    = ir[DATA_W-1 -: OPC_W];
  assign ir_ra     = ir[RA_LSB +: REG_FIELD_W];
  assign ir_rb     = ir[RB_LSB +: REG_FIELD_W];
  assign ir_rc     = ir[RC_LSB +: REG_FIELD_W];
  assign unused_ir = ^ir[RC_LSB-1:0];

  logic [3:0]             state, state_nxt;
  logic                   t1_first;
  logic [TMO_W-1:0]       tmo_cnt;
  logic [OPC_W-1:0]       opc_q;
  logic [REG_FIELD_W-1:0] ra_q, rc_q;

  logic ir_multi, instr_ok, multi_q, tmo_expire;
  logic out_en, in_en;
  logic [REG_FIELD_W-1:0] out_idx, in_idx;

  // Decode of the freshly loaded IR; only consulted while in T3.
  always_comb begin
    ir_multi = is_multicycle(32'(ir_opc));
    instr_ok = is_legal_op(32'(ir_opc))
               && (int'(ir_rb) < NUM_REGS)
               && (int'(ir_rc) < NUM_REGS)
               && (ir_multi || (int'(ir_ra) < NUM_REGS));
  end

  assign multi_q    = is_multicycle(32'(opc_q));
  assign tmo_expire = (state == S_WAIT) && !alu_done && (tmo_cnt == TMO_LAST);

  always_comb begin
    state_nxt = S_RESET;
    case (state)
      S_RESET: state_nxt = run ? S_T0 : S_HALT;
      S_HALT:  state_nxt = (run && !fault) ? S_T0 : S_HALT;
      S_T0:    state_nxt = S_T1;
      S_T1:    state_nxt = mem_rdy ? S_T2 : S_T1;
      S_T2:    state_nxt = S_T3;
      S_T3:    state_nxt = instr_ok ? S_T4 : S_HALT;
      S_T4:    state_nxt = multi_q ? S_WAIT : S_T5;
      S_WAIT:  state_nxt = alu_done ? S_T5 : (tmo_expire ? S_HALT : S_WAIT);
      S_T5:    state_nxt = multi_q ? S_T6 : (run ? S_T0 : S_HALT);
      S_T6:    state_nxt = run ? S_T0 : S_HALT;
      default: state_nxt = S_RESET;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!clear) begin
      state    <= S_RESET;
      fault    <= 1'b0;
      tmo_cnt  <= '0;
      t1_first <= 1'b0;
    end else begin
      state    <= state_nxt;
      t1_first <= (state == S_T0);
      tmo_cnt  <= (state == S_WAIT) ? tmo_cnt + 1'b1 : '0;
      if (((state == S_T3) && !instr_ok) || tmo_expire) begin
        fault <= 1'b1;
      end
    end
  end

  // Instruction fields captured at the end of T3 for use in T4..T6.
  always_ff @(posedge Clock) begin
    if (state == S_T3) begin
      opc_q <= ir_opc;
      ra_q  <= ir_ra;
      rc_q  <= ir_rc;
    end
  end

  always_comb begin
    PCout     = 1'b0;
    Zlowout   = 1'b0;
    Zhighout  = 1'b0;
    MDRout    = 1'b0;
    MARin     = 1'b0;
    PCin      = 1'b0;
    MDRin     = 1'b0;
    IRin      = 1'b0;
    Yin       = 1'b0;
    Zin       = 1'b0;
    HIin      = 1'b0;
    LOin      = 1'b0;
    IncPC     = 1'b0;
    Read      = 1'b0;
    alu_op    = '0;
    alu_start = 1'b0;
    halted    = 1'b0;
    out_en    = 1'b0;
    out_idx   = '0;
    in_en     = 1'b0;
    in_idx    = '0;
    case (state)
      S_HALT: halted = 1'b1;
      S_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      S_T1: begin
        Read    = 1'b1;
        MDRin   = 1'b1;
        Zlowout = t1_first;
        PCin    = t1_first;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        out_en  = 1'b1;
        out_idx = ir_rb;
        Yin     = 1'b1;
      end
      S_T4: begin
        out_en    = 1'b1;
        out_idx   = rc_q;
        Zin       = 1'b1;
        alu_op    = opc_q;
        alu_start = multi_q;
      end
      S_WAIT: alu_op = opc_q;
      S_T5: begin
        Zlowout = 1'b1;
        LOin    = multi_q;
        in_en   = !multi_q;
        in_idx  = ra_q;
      end
      S_T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
      end
      default: ;
    endcase
  end

  onehot_decoder #(.NUM_REGS(NUM_REGS), .IDX_W(REG_FIELD_W)) u_reg_out_dec (
    .en     (out_en),
    .idx    (out_idx),
    .onehot (reg_out)
  );

  onehot_decoder #(.NUM_REGS(NUM_REGS), .IDX_W(REG_FIELD_W)) u_reg_in_dec (
    .en     (in_en),
    .idx    (in_idx),
    .onehot (reg_in)
  );

endmodule
